// File: rtl/twiddle_ram_loader.sv
// Copies a master twiddle table into per-stage RAMs: entry i*2^s lands at address i of stage s.
// Latency is T+3 cycles from load_req to load_done at one entry per clock; load_req is dropped while a load runs.
module twiddle_ram_loader #(
    parameter int W          = 32,
    parameter int radix      = 16,
    parameter int NUM_stages = $clog2(radix),
    parameter int ADDR_WIDTH = $clog2(radix / 2)
) (
    input  logic                                    clk,
    input  logic                                    rst,
    input  logic                                    load_req,
    input  logic [NUM_stages-1:0]                   stage_mask,
    output logic                                    tw_rd_en,
    output logic [ADDR_WIDTH-1:0]                   tw_rd_addr,
    input  logic [W-1:0]                            tw_rd_data,
    output logic [NUM_stages-1:0]                   write_en_array,
    output logic [NUM_stages-1:0][ADDR_WIDTH-1:0]   write_addr_array,
    output logic [NUM_stages-1:0][W-1:0]            write_data_array,
    output logic                                    busy,
    output logic                                    load_done
);
    localparam int SW = (NUM_stages > 1) ? $clog2(NUM_stages) : 1;

    typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;

    state_t                                r_state;
    state_t                                w_state_nxt;
    logic [NUM_stages-1:0]                 r_mask;
    logic [SW-1:0]                         r_stage;
    logic [ADDR_WIDTH-1:0]                 r_idx;
    logic                                  r_drain_cnt;

    logic                                  r_p_vld;
    logic [SW-1:0]                         r_p_stage;
    logic [ADDR_WIDTH-1:0]                 r_p_idx;

    logic [NUM_stages-1:0]                 r_wr_en;
    logic [NUM_stages-1:0][ADDR_WIDTH-1:0] r_wr_addr;
    logic [NUM_stages-1:0][W-1:0]          r_wr_data;

    logic [SW-1:0]                         w_first_stage;
    logic [SW-1:0]                         w_next_stage;
    logic                                  w_has_next;
    logic                                  w_last_idx;

    // Descending scans so the lowest qualifying stage wins.
    always_comb begin
        w_first_stage = '0;
        w_next_stage  = r_stage;
        w_has_next    = 1'b0;
        for (int s = NUM_stages - 1; s >= 0; s--) begin
            if (stage_mask[s]) begin
                w_first_stage = SW'(s);
            end
            if (r_mask[s] && (SW'(s) > r_stage)) begin
                w_next_stage = SW'(s);
                w_has_next   = 1'b1;
            end
        end
    end

    assign w_last_idx = (r_idx == ADDR_WIDTH'((radix >> (r_stage + 1)) - 1));

    always_comb begin
        w_state_nxt = r_state;
        tw_rd_en    = 1'b0;
        tw_rd_addr  = '0;
        busy        = 1'b0;
        load_done   = 1'b0;
        case (r_state)
            IDLE: begin
                if (load_req) begin
                    w_state_nxt = (|stage_mask) ? READ : DRAIN;
                end
            end
            READ: begin
                tw_rd_en   = 1'b1;
                tw_rd_addr = r_idx << r_stage;
                busy       = 1'b1;
                if (w_last_idx && !w_has_next) begin
                    w_state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                busy = 1'b1;
                if (r_drain_cnt) begin
                    w_state_nxt = DONE;
                end
            end
            DONE: begin
                load_done   = 1'b1;
                w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_mask      <= '0;
            r_stage     <= '0;
            r_idx       <= '0;
            r_drain_cnt <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            case (r_state)
                IDLE: begin
                    if (load_req) begin
                        r_mask      <= stage_mask;
                        r_stage     <= w_first_stage;
                        r_idx       <= '0;
                        r_drain_cnt <= 1'b0;
                    end
                end
                READ: begin
                    if (w_last_idx) begin
                        r_idx   <= '0;
                        r_stage <= w_next_stage;
                    end else begin
                        r_idx <= r_idx + ADDR_WIDTH'(1);
                    end
                end
                DRAIN:   r_drain_cnt <= ~r_drain_cnt;
                default: ;
            endcase
        end
    end

    // Tag stage lines the read up with tw_rd_data; the write lane registers are the second stage.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_p_vld   <= 1'b0;
            r_p_stage <= '0;
            r_p_idx   <= '0;
            r_wr_en   <= '0;
            r_wr_addr <= '0;
            r_wr_data <= '0;
        end else begin
            r_p_vld   <= (r_state == READ);
            r_p_stage <= r_stage;
            r_p_idx   <= r_idx;
            r_wr_en   <= '0;
            r_wr_addr <= '0;
            r_wr_data <= '0;
            if (r_p_vld) begin
                r_wr_en[r_p_stage]   <= 1'b1;
                r_wr_addr[r_p_stage] <= r_p_idx;
                r_wr_data[r_p_stage] <= tw_rd_data;
            end
        end
    end

    assign write_en_array   = r_wr_en;
    assign write_addr_array = r_wr_addr;
    assign write_data_array = r_wr_data;

endmodule

// File: tb/tb_twiddle_ram_loader.sv
// Bench for twiddle_ram_loader: radix-16 instance checked cycle by cycle against a list-based model, plus a radix-4 instance.
module tb_twiddle_ram_loader;
    localparam int W   = 32;
    localparam int R   = 16;
    localparam int NS  = 4;
    localparam int AW  = 3;
    localparam int BW  = 1 + AW + NS + NS * AW + NS * W + 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                      rst;
    logic                      load_req;
    logic [NS-1:0]             stage_mask;
    logic                      tw_rd_en;
    logic [AW-1:0]             tw_rd_addr;
    logic [W-1:0]              tw_rd_data;
    logic [NS-1:0]             wen;
    logic [NS-1:0][AW-1:0]     waddr;
    logic [NS-1:0][W-1:0]      wdata;
    logic                      busy;
    logic                      load_done;

    logic                      load_req4;
    logic [1:0]                stage_mask4;
    logic                      tw_rd_en4;
    logic [0:0]                tw_rd_addr4;
    logic [W-1:0]              tw_rd_data4;
    logic [1:0]                wen4;
    logic [1:0][0:0]           waddr4;
    logic [1:0][W-1:0]         wdata4;
    logic                      busy4;
    logic                      load_done4;

    twiddle_ram_loader #(.W(W), .radix(R)) dut (
        .clk(clk), .rst(rst), .load_req(load_req), .stage_mask(stage_mask),
        .tw_rd_en(tw_rd_en), .tw_rd_addr(tw_rd_addr), .tw_rd_data(tw_rd_data),
        .write_en_array(wen), .write_addr_array(waddr), .write_data_array(wdata),
        .busy(busy), .load_done(load_done)
    );

    twiddle_ram_loader #(.W(W), .radix(4)) dut4 (
        .clk(clk), .rst(rst), .load_req(load_req4), .stage_mask(stage_mask4),
        .tw_rd_en(tw_rd_en4), .tw_rd_addr(tw_rd_addr4), .tw_rd_data(tw_rd_data4),
        .write_en_array(wen4), .write_addr_array(waddr4), .write_data_array(wdata4),
        .busy(busy4), .load_done(load_done4)
    );

    // Master tables: one-cycle read latency, garbage when not read.
    logic [W-1:0] mem  [R/2];
    logic [W-1:0] mem4 [2];
    always @(posedge clk) tw_rd_data  <= tw_rd_en  ? mem[tw_rd_addr]   : 32'hDEAD_BEEF;
    always @(posedge clk) tw_rd_data4 <= tw_rd_en4 ? mem4[tw_rd_addr4] : 32'hDEAD_BEEF;

    logic [W-1:0] ram [NS][R/2];
    int           wcnt [NS];
    int           done_cyc;
    int           n_checks = 0;
    int           n_pass   = 0;

    typedef struct {
        logic [NS-1:0]       mask;
        int                  done;
        logic [NS-1:0][7:0]  cnt;
    } vec_t;
    vec_t tbl [6];

    typedef struct packed {
        logic            rd;
        logic            ra;
        logic [1:0]      we;
        logic [1:0]      wa;
        logic [1:0][31:0] wd;
        logic            bsy;
        logic            dn;
    } v4_t;
    v4_t tbl4 [8];

    logic [W-1:0] plan [8] = '{32'h14E1, 32'h092F, 32'h10AA, 32'h061E,
                               32'h0425, 32'h0E0E, 32'h1B30, 32'h15C1};
    logic [W-1:0] exp_s1 [4] = '{32'h14E1, 32'h10AA, 32'h0425, 32'h1B30};
    logic [W-1:0] exp_s2 [2] = '{32'h14E1, 32'h0425};

    task automatic check(input bit ok, input string msg);
        n_checks++;
        if (ok) n_pass++;
        else $display("FAIL %s", msg);
    endtask

    // Cycle 0 is the current cycle (called just after a negedge).
    task automatic run16(input logic [NS-1:0] mask, input logic [63:0] req_extra, input int rst_at);
        int qs[$];
        int qi[$];
        int T;
        int j;
        logic                  e_rd;
        logic [AW-1:0]         e_ra;
        logic [NS-1:0]         e_we;
        logic [NS-1:0][AW-1:0] e_wa;
        logic [NS-1:0][W-1:0]  e_wd;
        logic                  e_busy;
        logic                  e_done;
        logic [BW-1:0]         got;
        logic [BW-1:0]         exp;
        for (int s = 0; s < NS; s++) begin
            wcnt[s] = 0;
            if (mask[s]) begin
                for (int i = 0; i < (R >> (s + 1)); i++) begin
                    qs.push_back(s);
                    qi.push_back(i);
                end
            end
        end
        T        = qs.size();
        done_cyc = -1;
        load_req   = 1'b1;
        stage_mask = mask;
        for (int k = 1; k <= T + 4; k++) begin
            @(negedge clk);
            e_rd = 1'b0; e_ra = '0; e_we = '0; e_wa = '0; e_wd = '0; e_busy = 1'b0; e_done = 1'b0;
            if (!(rst_at > 0 && k > rst_at)) begin
                if (k >= 1 && k <= T) begin
                    e_rd = 1'b1;
                    e_ra = AW'(qi[k-1] << qs[k-1]);
                end
                if (k >= 3 && k <= T + 2) begin
                    j = k - 3;
                    e_we[qs[j]] = 1'b1;
                    e_wa[qs[j]] = AW'(qi[j]);
                    e_wd[qs[j]] = mem[qi[j] << qs[j]];
                end
                e_busy = (k >= 1 && k <= T + 2);
                e_done = (k == T + 3);
            end
            got = {tw_rd_en, tw_rd_addr, wen, waddr, wdata, busy, load_done};
            exp = {e_rd, e_ra, e_we, e_wa, e_wd, e_busy, e_done};
            check(got === exp, $sformatf("cycle%0d mask=%b got=%h exp=%h", k, mask, got, exp));
            for (int s = 0; s < NS; s++) begin
                if (wen[s]) begin
                    wcnt[s]++;
                    ram[s][waddr[s]] = wdata[s];
                end
            end
            if (load_done && done_cyc < 0) done_cyc = k;
            load_req   = req_extra[k];
            rst        = (k == rst_at);
            stage_mask = NS'($urandom);
        end
    endtask

    task automatic check_ram(input logic [NS-1:0] mask);
        for (int s = 0; s < NS; s++) begin
            if (mask[s]) begin
                for (int i = 0; i < (R >> (s + 1)); i++) begin
                    check(ram[s][i] === mem[i << s],
                          $sformatf("ram s%0d a%0d got=%h exp=%h", s, i, ram[s][i], mem[i << s]));
                end
            end
        end
    endtask

    function automatic int wtotal();
        int t = 0;
        for (int s = 0; s < NS; s++) t += wcnt[s];
        return t;
    endfunction

    initial begin
        logic [NS-1:0][7:0] gcnt;
        logic [71:0]        got4;
        logic [NS-1:0]      m;

        tbl[0] = '{4'b1111, 18, {8'd1, 8'd2, 8'd4, 8'd8}};
        tbl[1] = '{4'b0101, 13, {8'd0, 8'd2, 8'd0, 8'd8}};
        tbl[2] = '{4'b0000,  3, {8'd0, 8'd0, 8'd0, 8'd0}};
        tbl[3] = '{4'b1000,  4, {8'd1, 8'd0, 8'd0, 8'd0}};
        tbl[4] = '{4'b0110,  9, {8'd0, 8'd2, 8'd4, 8'd0}};
        tbl[5] = '{4'b1010,  8, {8'd1, 8'd0, 8'd4, 8'd0}};

        tbl4[1] = '{1'b1, 1'b0, 2'b00, 2'b00, 64'h0, 1'b1, 1'b0};
        tbl4[2] = '{1'b1, 1'b1, 2'b00, 2'b00, 64'h0, 1'b1, 1'b0};
        tbl4[3] = '{1'b1, 1'b0, 2'b01, 2'b00, {32'h0, 32'h061E}, 1'b1, 1'b0};
        tbl4[4] = '{1'b0, 1'b0, 2'b01, 2'b01, {32'h0, 32'h15C1}, 1'b1, 1'b0};
        tbl4[5] = '{1'b0, 1'b0, 2'b10, 2'b00, {32'h061E, 32'h0}, 1'b1, 1'b0};
        tbl4[6] = '{1'b0, 1'b0, 2'b00, 2'b00, 64'h0, 1'b0, 1'b1};
        tbl4[7] = '{1'b0, 1'b0, 2'b00, 2'b00, 64'h0, 1'b0, 1'b0};
        tbl4[0] = tbl4[7];

        rst = 1'b1; load_req = 1'b0; stage_mask = '1; load_req4 = 1'b0; stage_mask4 = 2'b11;
        for (int i = 0; i < R / 2; i++) mem[i] = plan[i];
        mem4[0] = 32'h061E; mem4[1] = 32'h15C1;
        for (int s = 0; s < NS; s++) for (int i = 0; i < R / 2; i++) ram[s][i] = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check({tw_rd_en, tw_rd_addr, wen, waddr, wdata, busy, load_done} === '0, "reset16 outputs not zero");
        check({tw_rd_en4, tw_rd_addr4, wen4, waddr4, wdata4, busy4, load_done4} === '0, "reset4 outputs not zero");
        rst = 1'b0;
        @(negedge clk);

        // Full load with the reference table, then spot-check stage RAMs.
        run16(4'b1111, 64'h0, 0);
        for (int i = 0; i < 8; i++) check(ram[0][i] === plan[i], $sformatf("plan s0 a%0d got=%h", i, ram[0][i]));
        for (int i = 0; i < 4; i++) check(ram[1][i] === exp_s1[i], $sformatf("plan s1 a%0d got=%h exp=%h", i, ram[1][i], exp_s1[i]));
        for (int i = 0; i < 2; i++) check(ram[2][i] === exp_s2[i], $sformatf("plan s2 a%0d got=%h exp=%h", i, ram[2][i], exp_s2[i]));
        check(ram[3][0] === 32'h14E1, $sformatf("plan s3 a0 got=%h exp=14e1", ram[3][0]));

        for (int v = 0; v < 6; v++) begin
            @(negedge clk);
            run16(tbl[v].mask, 64'h0, 0);
            for (int s = 0; s < NS; s++) gcnt[s] = 8'(wcnt[s]);
            check(done_cyc == tbl[v].done, $sformatf("vec%0d done cycle got=%0d exp=%0d", v, done_cyc, tbl[v].done));
            check(gcnt === tbl[v].cnt, $sformatf("vec%0d write counts got=%h exp=%h", v, gcnt, tbl[v].cnt));
        end

        // Requests during busy and in the done cycle are dropped; cycle 19 starts a back-to-back load.
        @(negedge clk);
        run16(4'b1111, 64'h0006_0424, 0);
        check(wtotal() == 15, $sformatf("repeat-req writes got=%0d exp=15", wtotal()));
        run16(4'b1111, 64'h0, 0);
        check(done_cyc == 18, $sformatf("back-to-back done got=%0d exp=18", done_cyc));

        // Reset in cycle 8, then a fresh load with new contents.
        @(negedge clk);
        run16(4'b1111, 64'h0, 8);
        check(wtotal() == 6, $sformatf("reset-mid writes got=%0d exp=6", wtotal()));
        check(done_cyc == -1, $sformatf("reset-mid load_done seen in cycle %0d", done_cyc));
        for (int i = 0; i < R / 2; i++) mem[i] = $urandom;
        run16(4'b1111, 64'h0, 0);
        check_ram(4'b1111);

        for (int n = 0; n < 20; n++) begin
            for (int i = 0; i < R / 2; i++) mem[i] = $urandom;
            m = NS'($urandom);
            repeat ($urandom_range(0, 2)) @(negedge clk);
            run16(m, 64'h0, 0);
            check_ram(m);
        end

        // Radix-4 instance.
        @(negedge clk);
        load_req4 = 1'b1;
        for (int k = 1; k <= 7; k++) begin
            @(negedge clk);
            load_req4 = 1'b0;
            got4 = {tw_rd_en4, tw_rd_addr4, wen4, waddr4, wdata4, busy4, load_done4};
            check(got4 === tbl4[k], $sformatf("radix4 cycle%0d got=%h exp=%h", k, got4, tbl4[k]));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
